// File: rtl/piso_buffer_pkg.sv
// Shared helpers for the piso_buffer slice: modular index arithmetic
// used by both the round-robin arbiter and the drain pointer update.
package piso_buffer_pkg;

  // Both operands are assumed to be in [0, n-1], so one subtraction wraps.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/piso_buffer_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping N-1 -> 0. Reusable by any round-robin consumer.
module rr_arbiter
  import piso_buffer_pkg::*;
#(
  parameter int N = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any_req
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(int'(ptr), k, N)]) begin
        gnt_idx = IDXW'(wrap_add(int'(ptr), k, N));
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/piso_buffer.sv
// Parallel-load slot buffer drained one item per handshake in round-robin order.
// Each producer owns one slot; a single consumer sees out_idx/d_out/out_valid.
module piso_buffer
  import piso_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 8,
  localparam int IDXW  = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in [LENGTH],
  input  logic [LENGTH-1:0] we,
  output logic [LENGTH-1:0] used_pos,
  output logic [WIDTH-1:0] d_out,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  slot [LENGTH];
  logic [IDXW-1:0]   rr_ptr;
  logic              accept;
  logic              load_out;
  logic [LENGTH-1:0] drain_mask;
  logic [LENGTH-1:0] req;
  logic [IDXW-1:0]   arb_ptr;
  logic [IDXW-1:0]   gnt_idx;
  logic              any_req;

  assign accept    = (state == PRESENT) && out_ready;
  assign out_valid = (state == PRESENT);

  always_comb begin
    drain_mask = '0;
    if (accept) drain_mask[out_idx] = 1'b1;
  end

  // The slot being drained is excluded this cycle, so a same-cycle rewrite of
  // it only becomes eligible once the pointer has moved past it.
  assign req     = used_pos & ~drain_mask;
  assign arb_ptr = accept ? IDXW'(wrap_add(int'(out_idx), 1, LENGTH)) : rr_ptr;

  rr_arbiter #(.N(LENGTH)) u_arb (
    .req     (req),
    .ptr     (arb_ptr),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = PRESENT;
          load_out  = 1'b1;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          load_out  = any_req;
          state_nxt = any_req ? PRESENT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A slot accepts a write only if it is free once this cycle's drain is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LENGTH; i++) slot[i] <= '0;
      used_pos <= '0;
      rr_ptr   <= '0;
      out_idx  <= '0;
      d_out    <= '0;
    end else begin
      for (int i = 0; i < LENGTH; i++) begin
        if (we[i] && (!used_pos[i] || drain_mask[i])) begin
          slot[i]     <= d_in[i];
          used_pos[i] <= 1'b1;
        end else if (drain_mask[i]) begin
          used_pos[i] <= 1'b0;
        end
      end
      if (accept) rr_ptr <= arb_ptr;
      if (load_out) begin
        out_idx <= gnt_idx;
        d_out   <= slot[gnt_idx];
      end
    end
  end

endmodule

// File: tb/tb_piso_buffer.sv
// Self-checking bench for piso_buffer: directed scenarios with literal
// expectations, then randomized traffic compared against a queue-based model.
module tb_piso_buffer;

  localparam int W = 32;
  localparam int L = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d_in [L];
  logic [L-1:0]  we;
  logic [L-1:0]  used_pos;
  logic [W-1:0]  d_out;
  logic [2:0]    out_idx;
  logic          out_valid;
  logic          out_ready;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Reference state: what is stored, what is shown, and where the next search starts.
  logic [L-1:0]  m_used;
  logic [W-1:0]  m_data [L];
  int            m_rr;
  bit            m_valid;
  int            m_idx;
  logic [W-1:0]  m_dout;

  piso_buffer #(.WIDTH(W), .LENGTH(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .we        (we),
    .used_pos  (used_pos),
    .d_out     (d_out),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    m_used  = '0;
    m_rr    = 0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_dout  = '0;
    for (int i = 0; i < L; i++) m_data[i] = '0;
  endtask

  // One clock edge of the buffer, computed from the pre-edge state and inputs.
  task automatic modelStep();
    logic [L-1:0] occ;
    int order[$];
    bit take;
    occ  = m_used;
    take = m_valid && out_ready;
    if (take) begin
      occ[m_idx] = 1'b0;
      m_rr = (m_idx + 1) % L;
    end
    if (!m_valid || take) begin
      order = {};
      for (int k = 0; k < L; k++)
        if (occ[(m_rr + k) % L]) order.push_back((m_rr + k) % L);
      if (order.size() > 0) begin
        m_valid = 1'b1;
        m_idx   = order[0];
        m_dout  = m_data[order[0]];
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < L; i++) begin
      if (we[i] && !occ[i]) begin
        m_data[i] = d_in[i];
        occ[i]    = 1'b1;
      end
    end
    m_used = occ;
  endtask

  task automatic applyStimulus(input logic [L-1:0] w, input logic r);
    we        = w;
    out_ready = r;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput();
    check("used_pos", 32'(used_pos), 32'(m_used));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_idx", 32'(out_idx), m_idx);
      check("d_out", d_out, m_dout);
    end
  endtask

  always @(negedge clk) if (cmp_en) checkOutput();

  initial begin
    logic [W-1:0] fill [L];
    rst       = 1'b1;
    we        = '0;
    out_ready = 1'b0;
    for (int i = 0; i < L; i++) d_in[i] = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    check("rst used_pos", 32'(used_pos), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst d_out", d_out, 32'h0);
    check("rst out_idx", 32'(out_idx), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // 1: single write, presented after one idle cycle, then accepted
    d_in[0] = 32'hAAAA_0000;
    applyStimulus(8'h01, 1'b0);
    check("t1 used", 32'(used_pos), 32'h01);
    applyStimulus(8'h00, 1'b1);
    check("t1 valid", 32'(out_valid), 32'h1);
    check("t1 idx", 32'(out_idx), 32'h0);
    check("t1 data", d_out, 32'hAAAA_0000);
    applyStimulus(8'h00, 1'b1);
    check("t1 drained used", 32'(used_pos), 32'h0);
    check("t1 drained valid", 32'(out_valid), 32'h0);

    // 2: slots 2,5,7 together, back-to-back drain
    d_in[2] = 32'h2222_2222; d_in[5] = 32'h5555_5555; d_in[7] = 32'h7777_7777;
    applyStimulus(8'hA4, 1'b1);
    applyStimulus(8'h00, 1'b1);
    check("t2 idx a", 32'(out_idx), 32'd2);
    check("t2 data a", d_out, 32'h2222_2222);
    applyStimulus(8'h00, 1'b1);
    check("t2 idx b", 32'(out_idx), 32'd5);
    applyStimulus(8'h00, 1'b1);
    check("t2 idx c", 32'(out_idx), 32'd7);
    check("t2 data c", d_out, 32'h7777_7777);
    applyStimulus(8'h00, 1'b1);
    check("t2 empty", 32'(out_valid), 32'h0);

    // 3: slot 3 held with out_ready low while slots 1 and 4 arrive
    d_in[3] = 32'h3333_0003; d_in[1] = 32'h1111_0001; d_in[4] = 32'h4444_0004;
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus((c == 0) ? 8'h12 : 8'h00, 1'b0);
      check("t3 hold idx", 32'(out_idx), 32'd3);
      check("t3 hold data", d_out, 32'h3333_0003);
    end
    applyStimulus(8'h00, 1'b1);
    check("t3 next idx", 32'(out_idx), 32'd4);
    applyStimulus(8'h00, 1'b1);
    check("t3 last idx", 32'(out_idx), 32'd1);
    check("t3 last data", d_out, 32'h1111_0001);
    applyStimulus(8'h00, 1'b1);

    // 4: write to an occupied slot is dropped; write during its drain reloads it
    d_in[6] = 32'hXXXX_0006 & 32'h0000_FFFF | 32'h0A0A_0000;
    applyStimulus(8'h40, 1'b0);
    applyStimulus(8'h00, 1'b0);
    d_in[6] = 32'hBBBB_0006;
    applyStimulus(8'h40, 1'b0);
    check("t4 drop data", d_out, 32'h0A0A_0006);
    d_in[6] = 32'hCCCC_0006;
    applyStimulus(8'h40, 1'b1);
    check("t4 reload used", 32'(used_pos), 32'h40);
    check("t4 reload valid", 32'(out_valid), 32'h0);
    applyStimulus(8'h00, 1'b0);
    check("t4 new data", d_out, 32'hCCCC_0006);
    applyStimulus(8'h00, 1'b1);

    // 5: fill everything, extra writes dropped, drain in rotation from slot 7
    for (int i = 0; i < L; i++) begin
      fill[i] = 32'hF000_0000 | 32'(i);
      d_in[i] = fill[i];
    end
    applyStimulus(8'hFF, 1'b0);
    check("t5 full", 32'(used_pos), 32'hFF);
    for (int i = 0; i < L; i++) d_in[i] = 32'hDEAD_0000 | 32'(i);
    applyStimulus(8'hFF, 1'b0);
    for (int k = 0; k < L; k++) begin
      check("t5 drain idx", 32'(out_idx), 32'((7 + k) % L));
      check("t5 drain data", d_out, fill[(7 + k) % L]);
      applyStimulus(8'h00, 1'b1);
    end
    check("t5 empty", 32'(used_pos), 32'h0);

    // 6: asynchronous reset while presenting
    d_in[0] = 32'h0000_1000; d_in[1] = 32'h0000_1001; d_in[2] = 32'h0000_1002;
    applyStimulus(8'h07, 1'b0);
    applyStimulus(8'h00, 1'b0);
    check("t6 pre valid", 32'(out_valid), 32'h1);
    cmp_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6 rst used", 32'(used_pos), 32'h0);
    check("t6 rst valid", 32'(out_valid), 32'h0);
    check("t6 rst data", d_out, 32'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    d_in[5] = 32'h5050_5050;
    applyStimulus(8'h20, 1'b0);
    applyStimulus(8'h00, 1'b0);
    check("t6 after idx", 32'(out_idx), 32'd5);
    check("t6 after data", d_out, 32'h5050_5050);

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < L; i++) d_in[i] = $urandom;
      applyStimulus(L'($urandom & $urandom), ($urandom_range(0, 9) < 6));
    end
    applyStimulus(8'h00, 1'b0);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
